// File: rtl/fibonacci_stream_packer_if.sv
// rtl/fibonacci_stream_packer_if.sv - term input and tagged output stream bundle for the packer
interface fibonacci_stream_packer_if #(
  parameter int W    = 32,
  parameter int IDXW = 8
);
  logic            in_valid;
  logic [W-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [IDXW-1:0] out_idx;
  logic            out_wrap;

  // master: generator/consumer environment; slave: the packer itself
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_idx, out_wrap
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_idx, out_wrap
  );
endinterface

// File: rtl/fibonacci_stream_packer.sv
// rtl/fibonacci_stream_packer.sv - tags Fibonacci terms with index/wrap and buffers them in a FWFT FIFO
module fibonacci_stream_packer #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int IDXW  = 8,
  parameter int DROPW = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  fibonacci_stream_packer_if.slave      s,
  output logic                          full,
  output logic [DROPW-1:0]              drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = W + IDXW + 1;

  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [IDXW-1:0] idx_r;
  logic [W-1:0]    prev_r;
  logic            wrap_r;

  logic pop, push, drop, wrap_now, wrap_entry;

  assign full       = (count == CW'(DEPTH));
  assign s.out_valid = (count != '0);
  assign pop        = s.out_valid & s.out_ready;
  assign push       = s.in_valid & (~full | pop);
  assign drop       = s.in_valid & full & ~pop;
  // the sequence only decreases when the W-bit sum overflows
  assign wrap_now   = (idx_r != '0) && (s.in_data < prev_r);
  assign wrap_entry = wrap_r | wrap_now;

  assign {s.out_wrap, s.out_idx, s.out_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wrap_entry, idx_r, s.in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      idx_r    <= '0;
      prev_r   <= '0;
      wrap_r   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      // tag state advances for every captured term, pushed or dropped
      if (s.in_valid) begin
        idx_r  <= idx_r + 1'b1;
        prev_r <= s.in_data;
        wrap_r <= wrap_entry;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (drop_cnt != {DROPW{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule
